// File: rtl/add_rr.sv
// add_rr -- multi-flux tagged two-operand adder with round-robin arbitration.
//
// FLUX interleaved data fluxes share one signed adder. In each cycle the
// block pops one token from operand bank A and one from operand bank B for
// a single granted flux. It registers {flux tag, sum} in a one-deep output
// stage. The stage is pushed into the result FIFO bank one cycle later.
//
// Compile-time option:
//   ADD_RR_SAT_EN  defined   -> sum saturates to the signed DATA_WIDTH range
//                  undefined -> sum wraps (two's complement, low bits kept)
//
// Ports:
//   clk        in   single clock, all state on the rising edge
//   rst        in   asynchronous active-high reset
//   opA_empty  in   [FLUX]        per-flux empty of operand-A FIFO bank
//   opA_dout   in   [FLUX*WIDTH]  per-flux head token {tag, data}, flux i at i*WIDTH
//   opA_read   out  [FLUX]        per-flux pop strobe (one-hot or zero)
//   opB_*                         same as opA_*, for operand B
//   sum_full   in   [FLUX]        per-flux full of result FIFO bank
//   sum_write  out  1             push strobe for result bank (routed by tag)
//   sum_din    out  [WIDTH]       result token {tag, result}
module add_rr #(
  parameter  int FLUX       = 2,
  parameter  int DATA_WIDTH = 18,
  localparam int TAG_WIDTH  = $clog2(FLUX),
  localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLUX-1:0]         opA_empty,
  input  logic [FLUX*WIDTH-1:0]   opA_dout,
  output logic [FLUX-1:0]         opA_read,
  input  logic [FLUX-1:0]         opB_empty,
  input  logic [FLUX*WIDTH-1:0]   opB_dout,
  output logic [FLUX-1:0]         opB_read,
  input  logic [FLUX-1:0]         sum_full,
  output logic                    sum_write,
  output logic [WIDTH-1:0]        sum_din
);

  localparam logic [TAG_WIDTH:0] FLUX_W = (TAG_WIDTH+1)'(FLUX);

  logic                  vld_q, vld_d;
  logic [TAG_WIDTH-1:0]  stg_tag_q, stg_tag_d;
  logic [DATA_WIDTH-1:0] stg_data_q, stg_data_d;
  logic [TAG_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  logic [FLUX-1:0]       eligible;
  logic [DATA_WIDTH-1:0] a_data [FLUX];
  logic [DATA_WIDTH-1:0] b_data [FLUX];

  logic                  issue_ok;
  logic                  grant_vld;
  logic [TAG_WIDTH-1:0]  grant_idx;
  logic [TAG_WIDTH:0]    cand;
  logic [TAG_WIDTH:0]    ptr_nxt;
  logic [DATA_WIDTH-1:0] a_sel, b_sel;
  logic [DATA_WIDTH:0]   sum_ext;
  logic [DATA_WIDTH-1:0] result;

  // Incoming tag bits are deliberately ignored; the tag is regenerated from the grant.
  logic unused_dout;
  assign unused_dout = ^{opA_dout, opB_dout};

  // Per-flux eligibility, operand slicing and one-hot read strobes.
  for (genvar gi = 0; gi < FLUX; gi++) begin : g_flux
    assign eligible[gi] = ~opA_empty[gi] & ~opB_empty[gi] & ~sum_full[gi];
    assign a_data[gi]   = opA_dout[gi*WIDTH +: DATA_WIDTH];
    assign b_data[gi]   = opB_dout[gi*WIDTH +: DATA_WIDTH];
    assign opA_read[gi] = grant_vld && (grant_idx == TAG_WIDTH'(gi));
    assign opB_read[gi] = grant_vld && (grant_idx == TAG_WIDTH'(gi));
  end

  // Drain the stage whenever its own flux has room.
  assign sum_write = vld_q & ~sum_full[stg_tag_q];
  assign sum_din   = {stg_tag_q, stg_data_q};

  // A new token may enter when the stage is empty or empties this cycle.
  // Popping during reset would lose the operands, so reset blocks issue.
  assign issue_ok = ~rst & (~vld_q | sum_write);

  // Round-robin search starting at rr_ptr, wrapping modulo FLUX (also for
  // non-power-of-two FLUX, so tags >= FLUX are never produced).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < FLUX; k++) begin
      cand = {1'b0, rr_ptr_q} + (TAG_WIDTH+1)'(k);
      if (cand >= FLUX_W) begin
        cand = cand - FLUX_W;
      end
      if (issue_ok && !grant_vld && eligible[cand[TAG_WIDTH-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[TAG_WIDTH-1:0];
      end
    end
  end

  // Shared adder: the sum is formed one bit wider so that overflow is visible.
  always_comb begin
    a_sel   = a_data[grant_idx];
    b_sel   = b_data[grant_idx];
    sum_ext = {a_sel[DATA_WIDTH-1], a_sel} + {b_sel[DATA_WIDTH-1], b_sel};
  end

`ifdef ADD_RR_SAT_EN
  // Overflow when the extra sign bit disagrees with the result sign bit.
  always_comb begin
    result = sum_ext[DATA_WIDTH-1:0];
    if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
      result = sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_sum_msb;
  assign unused_sum_msb = sum_ext[DATA_WIDTH];
  assign result         = sum_ext[DATA_WIDTH-1:0];
`endif

  // Stage and pointer next-state.
  always_comb begin
    vld_d      = vld_q;
    stg_tag_d  = stg_tag_q;
    stg_data_d = stg_data_q;
    rr_ptr_d   = rr_ptr_q;
    ptr_nxt    = {1'b0, grant_idx} + (TAG_WIDTH+1)'(1);
    if (ptr_nxt >= FLUX_W) begin
      ptr_nxt = '0;
    end
    if (grant_vld) begin
      vld_d      = 1'b1;
      stg_tag_d  = grant_idx;
      stg_data_d = result;
      rr_ptr_d   = ptr_nxt[TAG_WIDTH-1:0];
    end else if (sum_write) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= 1'b0;
      stg_tag_q  <= '0;
      stg_data_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      vld_q      <= vld_d;
      stg_tag_q  <= stg_tag_d;
      stg_data_q <= stg_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_add_rr.sv
// Testbench for add_rr (FLUX=2, DATA_WIDTH=18). Compile with ADD_RR_SAT_EN
// defined to exercise the saturating build; expectations follow the same macro.
module tb_add_rr;
  localparam int FLUX = 2;
  localparam int DW   = 18;
  localparam int W    = DW + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      opA_empty, opB_empty, sum_full;
  logic [2*W-1:0]  opA_dout, opB_dout;
  logic [1:0]      opA_read, opB_read;
  logic            sum_write;
  logic [W-1:0]    sum_din;

  always #5 clk = ~clk;

  add_rr #(.FLUX(FLUX), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .opA_empty (opA_empty),
    .opA_dout  (opA_dout),
    .opA_read  (opA_read),
    .opB_empty (opB_empty),
    .opB_dout  (opB_dout),
    .opB_read  (opB_read),
    .sum_full  (sum_full),
    .sum_write (sum_write),
    .sum_din   (sum_din)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one pending result token plus the next flux to favour.
  logic        m_vld;
  int          m_tag;
  logic [17:0] m_data;
  int          m_ptr;

  // Sum of two signed 18-bit values computed with plain integers.
  function automatic logic [17:0] ref_add(logic [17:0] a, logic [17:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef ADD_RR_SAT_EN
    if (s > 131071) s = 131071;
    else if (s < -131072) s = -131072;
`endif
    return 18'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check outputs, advance model.
  task automatic cycle(input string tag, input logic [1:0] ae, input logic [1:0] be,
                       input logic [1:0] fu, input logic [17:0] a0, input logic [17:0] a1,
                       input logic [17:0] b0, input logic [17:0] b1);
    logic [17:0] av [2];
    logic [17:0] bv [2];
    logic        exp_wr, issue;
    logic [1:0]  exp_rd;
    int          g, f;
    @(posedge clk);
    #1;
    opA_empty = ae;
    opB_empty = be;
    sum_full  = fu;
    // Random junk in the incoming tag bits: the design must ignore them.
    opA_dout  = {1'($urandom), a1, 1'($urandom), a0};
    opB_dout  = {1'($urandom), b1, 1'($urandom), b0};
    #1;
    av[0] = a0; av[1] = a1; bv[0] = b0; bv[1] = b1;
    exp_wr = m_vld && !fu[m_tag];
    issue  = !m_vld || exp_wr;
    g = -1;
    if (issue) begin
      for (int k = 0; k < FLUX; k++) begin
        f = (m_ptr + k) % FLUX;
        if (g < 0 && !ae[f] && !be[f] && !fu[f]) g = f;
      end
    end
    exp_rd = (g >= 0) ? 2'(1 << g) : 2'b00;
    check({tag, ".wr"},  32'(sum_write), 32'(exp_wr));
    check({tag, ".rdA"}, 32'(opA_read),  32'(exp_rd));
    check({tag, ".rdB"}, 32'(opB_read),  32'(exp_rd));
    if (m_vld) check({tag, ".din"}, 32'(sum_din), 32'({1'(m_tag), m_data}));
    $display("cycle %-12s empA=%b empB=%b full=%b rd=%b wr=%b din=%05h", tag, ae, be, fu,
             opA_read, sum_write, sum_din);
    if (g >= 0) begin
      m_vld  = 1'b1;
      m_tag  = g;
      m_data = ref_add(av[g], bv[g]);
      m_ptr  = (g + 1) % FLUX;
    end else if (exp_wr) begin
      m_vld = 1'b0;
    end
  endtask

  function automatic logic [17:0] rnd18();
    return 18'($urandom);
  endfunction

  initial begin
    // Reset state.
    rst = 1'b1;
    opA_empty = 2'b11; opB_empty = 2'b11; sum_full = 2'b00;
    opA_dout = '0; opB_dout = '0;
    m_vld = 1'b0; m_tag = 0; m_data = '0; m_ptr = 0;
    repeat (2) @(posedge clk);
    #2;
    check("reset.wr",  32'(sum_write), 32'd0);
    check("reset.din", 32'(sum_din),   32'd0);
    check("reset.rdA", 32'(opA_read),  32'd0);
    check("reset.rdB", 32'(opB_read),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Flux 0 only, 5 + 7.
    cycle("f0_issue", 2'b10, 2'b10, 2'b00, 18'd5, rnd18(), 18'd7, rnd18());
    cycle("f0_drain", 2'b11, 2'b11, 2'b00, '0, '0, '0, '0);
    check("f0_sum", 32'(sum_din), 32'({1'b0, 18'd12}));

    // Both fluxes eligible: grants alternate, one token per cycle.
    repeat (6) cycle("rr_both", 2'b00, 2'b00, 2'b00, rnd18(), rnd18(), rnd18(), rnd18());
    cycle("rr_drain", 2'b11, 2'b11, 2'b00, '0, '0, '0, '0);

    // Overflow on flux 1.
    cycle("ovf_pos", 2'b01, 2'b01, 2'b00, '0, 18'h1FFFF, '0, 18'd1);
    cycle("ovf_neg", 2'b01, 2'b01, 2'b00, '0, 18'h20000, '0, 18'h3FFFF);
`ifdef ADD_RR_SAT_EN
    check("ovf_pos_val", 32'(sum_din), 32'({1'b1, 18'h1FFFF}));
`else
    check("ovf_pos_val", 32'(sum_din), 32'({1'b1, 18'h20000}));
`endif
    cycle("ovf_drain", 2'b11, 2'b11, 2'b00, '0, '0, '0, '0);
`ifdef ADD_RR_SAT_EN
    check("ovf_neg_val", 32'(sum_din), 32'({1'b1, 18'h20000}));
`else
    check("ovf_neg_val", 32'(sum_din), 32'({1'b1, 18'h1FFFF}));
`endif

    // Stage stalled on full flux 0 while flux 1 is pending.
    cycle("stall_issue", 2'b10, 2'b10, 2'b00, 18'd100, '0, 18'd23, '0);
    repeat (3) cycle("stall_hold", 2'b01, 2'b01, 2'b01, '0, rnd18(), '0, rnd18());
    cycle("stall_free", 2'b01, 2'b01, 2'b00, '0, 18'd9, '0, 18'd4);
    check("stall_free_rd", 32'(opA_read), 32'd2);
    cycle("stall_drain", 2'b11, 2'b11, 2'b00, '0, '0, '0, '0);

    // Flux 1 blocked by its full flag, then served once it clears.
    repeat (3) cycle("full1", 2'b00, 2'b00, 2'b10, rnd18(), rnd18(), rnd18(), rnd18());
    cycle("full1_free", 2'b00, 2'b00, 2'b00, rnd18(), rnd18(), rnd18(), rnd18());
    cycle("full1_drain", 2'b11, 2'b11, 2'b00, '0, '0, '0, '0);

    // Reset while the stage holds a token.
    cycle("rst_issue", 2'b10, 2'b10, 2'b00, rnd18(), '0, rnd18(), '0);
    @(posedge clk);
    #1;
    opA_empty = 2'b11; opB_empty = 2'b11; sum_full = 2'b00;
    #1;
    check("rst_pre.wr", 32'(sum_write), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async.wr", 32'(sum_write), 32'd0);
    check("rst_async.rd", 32'(opA_read),  32'd0);
    @(posedge clk);
    #1;
    check("rst_hold.wr", 32'(sum_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_vld = 1'b0; m_tag = 0; m_data = '0; m_ptr = 0;
    cycle("rst_first", 2'b00, 2'b00, 2'b00, rnd18(), rnd18(), rnd18(), rnd18());
    check("rst_first_rd", 32'(opA_read), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] ae, be, fu;
      ae = 2'($urandom) & 2'($urandom);
      be = 2'($urandom) & 2'($urandom);
      fu = 2'($urandom) & 2'($urandom) & 2'($urandom);
      cycle("random", ae, be, fu, rnd18(), rnd18(), rnd18(), rnd18());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
